// File: rtl/ride_event_tx.sv
// ride_event_tx: detects ride FSM snapshot changes, queues event bytes and
// sends them as 8E1 UART frames to the operator console.
module ride_event_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       alarm,
  input  logic [2:0] fault_code,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       tx_busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] CMAX = 8'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  tx_state_t tx_st, tx_st_n;
  logic [5:0] snap, last_snap;
  logic [1:0] seq;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [7:0] shreg, cnt;
  logic [2:0] bit_idx, bit_n;
  logic evt, full, empty, pop, push, drop, last, tx_n;
  assign snap = {alarm, state, fault_code};
  assign evt = snap != last_snap;
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign last = cnt == CMAX;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;
  assign tx_busy = tx_st != IDLE;
  assign bit_n = (tx_st == DATA && last) ? bit_idx + 3'd1 : bit_idx;
  // tx is computed from the next state so the line is registered and glitch-free
  always_comb begin
    tx_st_n = tx_st;
    pop = 1'b0;
    case (tx_st)
      IDLE: begin
        pop = !empty;
        if (!empty) tx_st_n = START;
      end
      START: if (last) tx_st_n = DATA;
      DATA: if (last && bit_idx == 3'd7) tx_st_n = PARITY;
      PARITY: if (last) tx_st_n = STOP;
      STOP: begin
        pop = last && !empty;
        if (last) tx_st_n = empty ? IDLE : START;
      end
      default: tx_st_n = IDLE;
    endcase
    tx_n = tx_st_n == START ? 1'b0 : tx_st_n == DATA ? shreg[bit_n] : tx_st_n == PARITY ? ^shreg : 1'b1;
  end
  always_ff @(posedge clk) if (push) mem[wp] <= {snap, seq};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st <= IDLE;
      tx <= 1'b1;
      overflow <= 1'b0;
      last_snap <= '0;
      seq <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      shreg <= '0;
      cnt <= '0;
      bit_idx <= '0;
    end else begin
      tx_st <= tx_st_n;
      tx <= tx_n;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      if (evt) last_snap <= snap;
      if (push) begin
        seq <= seq + 2'd1;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        shreg <= mem[rp];
        cnt <= '0;
        bit_idx <= '0;
      end else if (tx_st != IDLE) begin
        cnt <= last ? 8'd0 : cnt + 8'd1;
        if (tx_st == DATA && last) bit_idx <= bit_idx + 3'd1;
      end
    end
  end
endmodule
